memory_bank_client: RTL
=======================

// Module: memory_bank_client
// PURPOSE
//  Input-port-side counterpart of the per-bank shared-memory allocator. One instance per router input port.
//  It takes this port's grant bit and ready bit from every bank allocator and hands out shared VCs
//  only from banks that are granted to this port and ready.
//  It tracks per-VC buffer occupancy and lifecycle, and drives back the per-VC allocated and empty
//  status that each allocator needs before it can drain and move a bank.
// PARAMETERS
//  num_banks         5  number of shared memory banks (one allocator each)
//  num_vcs_per_bank  2  shared VCs per bank; total shared VCs N = num_banks*num_vcs_per_bank
//  buffer_depth      8  flit slots per shared VC
//  vc_idx_width      4  width of VC index buses; must satisfy 2**vc_idx_width >= N
// PORTS
//  clk                   in   1  clock
//  reset                 in   1  asynchronous active-low reset
//  memory_bank_grant_in  in   num_banks  bank b is owned by this port (bit b from allocator b)
//  ready_for_allocation  in   num_banks  bank b accepts new shared-VC allocations
//  alloc_req             in   1  head flit needs a shared VC
//  alloc_gnt             out  1  shared VC granted this cycle
//  alloc_vc              out  vc_idx_width  index of the granted VC (valid when alloc_gnt)
//  flit_wr / flit_wr_vc  in   1 / vc_idx_width  write one flit into the VC
//  flit_wr_tail          in   1  the written flit is a tail flit
//  flit_rd / flit_rd_vc  in   1 / vc_idx_width  read one flit out of the VC
//  allocated_shared_ivc  out  N  VC v is not IDLE; bank b owns bits [b*num_vcs_per_bank +: num_vcs_per_bank]
//  shared_ivc_empty      out  N  occupancy of VC v == 0
//  err_overflow / err_underflow / err_protocol  out  1 each  sticky error flags
// BEHAVIOUR
//  Reset (async, active-low)
//   - All VCs go IDLE and all occupancies go to 0.
//   - alloc_gnt=0, alloc_vc=0, allocated_shared_ivc=0, shared_ivc_empty=all 1s, all error flags=0.
//  Per-VC FSM: IDLE -> ACTIVE -> CLOSING -> IDLE
//   - IDLE -> ACTIVE: at the clock edge where the VC is granted.
//   - ACTIVE -> CLOSING: on a flit_wr_tail write to the VC.
//   - CLOSING -> IDLE: at the edge where the next occupancy is 0.
//   - A tail write with a simultaneous read leaving occupancy 0 goes ACTIVE -> IDLE directly.
//  Eligibility
//   - VC v, bank b = v/num_vcs_per_bank, is eligible iff VC v is IDLE, grant_in[b]=1 and ready[b]=1.
//  Allocation
//   - Combinational, same cycle as the request.
//   - alloc_gnt = alloc_req & any eligible VC.
//   - alloc_vc = lowest eligible index, fixed priority.
//   - alloc_vc = 0 when there is no grant.
//   - allocated_shared_ivc[v] rises on the following cycle (registered).
//   - At most one allocation per cycle. If nothing is eligible, alloc_gnt=0 and the requester retries.
//  Occupancy
//   - Width is clog2(buffer_depth+1).
//   - Write alone: +1. Read alone: -1. Write and read to the same VC in one cycle: unchanged.
//   - Writes and reads to different VCs in one cycle are both applied.
//  Error conditions (the offending operation is dropped, the sticky flag sets at the next edge, only reset clears it)
//   - Write to a VC at occupancy buffer_depth without a simultaneous read -> err_overflow.
//   - Read from a VC at occupancy 0 -> err_underflow. This holds even with a simultaneous write; there is no bypass.
//   - Write to an IDLE or CLOSING VC -> err_protocol.
//   - grant_in[b] deasserting while any VC of bank b is not IDLE or not empty -> err_protocol.
//     The state of those VCs is kept.
//  Other rules
//   - Index out of range (>= N) on wr or rd -> err_protocol; the operation is ignored.
//   - ready_for_allocation low blocks new grants only. ACTIVE and CLOSING VCs of that bank keep
//     accepting writes and reads until they drain to IDLE. This is what lets the allocator leave its
//     drain state.
//   - Reset asserted mid-packet: all state is cleared immediately. Flits in flight are lost.
// TESTING
//  1 Release reset with grant=5'b00100 and ready=5'b00100; pulse alloc_req.
//    -> alloc_gnt=1 and alloc_vc=4 in the same cycle; allocated_shared_ivc[4]=1 on the next cycle.
//  2 Same setup; hold alloc_req for 3 cycles.
//    -> grants VC 4, then VC 5, then alloc_gnt=0 (bank 2 exhausted).
//  3 Allocate VC 4; write 3 flits, the last with tail; then read 3 flits.
//    -> shared_ivc_empty[4] goes 1,0,0,0,0,0,1; allocated_shared_ivc[4] falls on the edge of the 3rd read.
//  4 Drop ready[2] while VC 4 holds 2 flits.
//    -> no new grants from bank 2; reads still drain VC 4; empty[4]=1 and allocated[4]=0 after the tail drains.
//  5 Write 9 flits to a VC with buffer_depth=8 -> err_overflow=1, occupancy stays 8.
//    Read an empty VC -> err_underflow=1.
//  6 Drop grant[2] while VC 5 is ACTIVE -> err_protocol=1, VC 5 state kept.
//    Assert reset mid-packet -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/memory_bank_client.sv
// Input-port-side shared-VC client of the per-bank memory allocators.
// Hands out shared VCs from banks granted to this port and ready, tracks per-VC occupancy and
// lifecycle, and reports per-VC allocated/empty status back to the bank allocators.
module memory_bank_client #(
  parameter int unsigned NumBanks      = 5,
  parameter int unsigned NumVcsPerBank = 2,
  parameter int unsigned BufferDepth   = 8,
  parameter int unsigned VcIdxWidth    = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumBanks-1:0]               memory_bank_grant_i,
  input  logic [NumBanks-1:0]               ready_for_allocation_i,
  input  logic                              alloc_req_i,
  output logic                              alloc_gnt_o,
  output logic [VcIdxWidth-1:0]             alloc_vc_o,
  input  logic                              flit_wr_i,
  input  logic [VcIdxWidth-1:0]             flit_wr_vc_i,
  input  logic                              flit_wr_tail_i,
  input  logic                              flit_rd_i,
  input  logic [VcIdxWidth-1:0]             flit_rd_vc_i,
  output logic [NumBanks*NumVcsPerBank-1:0] allocated_shared_ivc_o,
  output logic [NumBanks*NumVcsPerBank-1:0] shared_ivc_empty_o,
  output logic                              err_overflow_o,
  output logic                              err_underflow_o,
  output logic                              err_protocol_o
);

  localparam int unsigned NumVcs = NumBanks * NumVcsPerBank;
  localparam int unsigned OccW   = $clog2(BufferDepth + 1);
  localparam logic [OccW-1:0]       OccFull   = OccW'(BufferDepth);
  localparam logic [VcIdxWidth:0]   NumVcsIdx = (VcIdxWidth + 1)'(NumVcs);

  typedef enum logic [1:0] {StIdle, StActive, StClosing} vc_state_e;

  vc_state_e       state_q [NumVcs];
  vc_state_e       state_d [NumVcs];
  logic [OccW-1:0] occ_q   [NumVcs];
  logic [OccW-1:0] occ_d   [NumVcs];

  logic [NumBanks-1:0] grant_q;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unf_q, err_unf_d;
  logic                err_prot_q, err_prot_d;

  logic [NumVcs-1:0]   wr_sel, rd_sel, wr_ok, rd_ok;
  logic [NumVcs-1:0]   ovf_hit, unf_hit, prot_wr_hit;
  logic                wr_oob, rd_oob;
  logic [NumVcs-1:0]   eligible;
  logic                found;
  logic [VcIdxWidth-1:0] pick_vc;
  logic [NumBanks-1:0] bank_busy;
  logic [NumBanks-1:0] grant_drop_err;

  // Decode the write/read ports into per-VC accept and error hits.
  always_comb begin
    wr_sel      = '0;
    rd_sel      = '0;
    wr_ok       = '0;
    rd_ok       = '0;
    ovf_hit     = '0;
    unf_hit     = '0;
    prot_wr_hit = '0;
    wr_oob      = flit_wr_i && ({1'b0, flit_wr_vc_i} >= NumVcsIdx);
    rd_oob      = flit_rd_i && ({1'b0, flit_rd_vc_i} >= NumVcsIdx);
    for (int v = 0; v < NumVcs; v++) begin
      wr_sel[v] = flit_wr_i && (flit_wr_vc_i == VcIdxWidth'(v));
      rd_sel[v] = flit_rd_i && (flit_rd_vc_i == VcIdxWidth'(v));
      // No bypass: a read of an empty VC fails even if a write lands the same cycle.
      unf_hit[v] = rd_sel[v] && (occ_q[v] == '0);
      rd_ok[v]   = rd_sel[v] && (occ_q[v] != '0);
      prot_wr_hit[v] = wr_sel[v] && (state_q[v] != StActive);
      // A full VC still takes a write when a read frees a slot in the same cycle.
      ovf_hit[v] = wr_sel[v] && (state_q[v] == StActive) && (occ_q[v] == OccFull) && !rd_ok[v];
      wr_ok[v]   = wr_sel[v] && (state_q[v] == StActive) && !ovf_hit[v];
    end
  end

  // Eligibility and fixed-priority pick of the lowest eligible VC.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    pick_vc  = '0;
    for (int v = 0; v < NumVcs; v++) begin
      eligible[v] = (state_q[v] == StIdle) && memory_bank_grant_i[v / NumVcsPerBank]
                    && ready_for_allocation_i[v / NumVcsPerBank];
    end
    for (int v = NumVcs - 1; v >= 0; v--) begin
      if (eligible[v]) begin
        found   = 1'b1;
        pick_vc = VcIdxWidth'(v);
      end
    end
  end

  assign alloc_gnt_o = alloc_req_i && found;
  assign alloc_vc_o  = alloc_gnt_o ? pick_vc : '0;

  // A bank is busy while any of its VCs is in use or holds flits; losing its grant then is an error.
  always_comb begin
    bank_busy = '0;
    for (int v = 0; v < NumVcs; v++) begin
      if ((state_q[v] != StIdle) || (occ_q[v] != '0)) begin
        bank_busy[v / NumVcsPerBank] = 1'b1;
      end
    end
    grant_drop_err = grant_q & ~memory_bank_grant_i & bank_busy;
  end

  // Per-VC occupancy and lifecycle next state.
  always_comb begin
    for (int v = 0; v < NumVcs; v++) begin
      occ_d[v]   = occ_q[v];
      state_d[v] = state_q[v];
      if (wr_ok[v] && !rd_ok[v]) begin
        occ_d[v] = occ_q[v] + OccW'(1);
      end else if (rd_ok[v] && !wr_ok[v]) begin
        occ_d[v] = occ_q[v] - OccW'(1);
      end
      case (state_q[v])
        StIdle: begin
          if (alloc_gnt_o && (pick_vc == VcIdxWidth'(v))) begin
            state_d[v] = StActive;
          end
        end
        StActive: begin
          if (wr_ok[v] && flit_wr_tail_i) begin
            state_d[v] = (occ_d[v] == '0) ? StIdle : StClosing;
          end
        end
        StClosing: begin
          if (occ_d[v] == '0) begin
            state_d[v] = StIdle;
          end
        end
        default: state_d[v] = StIdle;
      endcase
    end
  end

  // Sticky error flags; only reset clears them.
  always_comb begin
    err_ovf_d  = err_ovf_q | (|ovf_hit);
    err_unf_d  = err_unf_q | (|unf_hit);
    err_prot_d = err_prot_q | (|prot_wr_hit) | wr_oob | rd_oob | (|grant_drop_err);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NumVcs; v++) begin
        state_q[v] <= StIdle;
        occ_q[v]   <= '0;
      end
      grant_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_prot_q <= 1'b0;
    end else begin
      for (int v = 0; v < NumVcs; v++) begin
        state_q[v] <= state_d[v];
        occ_q[v]   <= occ_d[v];
      end
      grant_q    <= memory_bank_grant_i;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_prot_q <= err_prot_d;
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    for (int v = 0; v < NumVcs; v++) begin
      allocated_shared_ivc_o[v] = (state_q[v] != StIdle);
      shared_ivc_empty_o[v]     = (occ_q[v] == '0);
    end
  end

  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;
  assign err_protocol_o  = err_prot_q;

endmodule
